// File: rtl/dclk_rx_pkg.sv
// dclk_rx_pkg
//   Shared sizes and state encoding for the serial link receiver.
//   HDR_SZ, PL_SZ, ADDR_SZ : flit field sizes; FLIT_W is their sum.
//   CNT_W                  : width of the receive bit counter.
//   rx_state_e             : receiver state encoding (IDLE/RECV/HOLD).
package dclk_rx_pkg;

   localparam int HDR_SZ  = 2;
   localparam int PL_SZ   = 8;
   localparam int ADDR_SZ = 4;
   localparam int FLIT_W  = HDR_SZ + PL_SZ + ADDR_SZ;
   localparam int CNT_W   = $clog2(FLIT_W);

   typedef enum logic [1:0] {
      RX_IDLE = 2'd0,
      RX_RECV = 2'd1,
      RX_HOLD = 2'd2
   } rx_state_e;

endpackage

// File: rtl/dclk_rx_bit_sync.sv
// dclk_rx_bit_sync
//   Two-flop synchroniser for a single asynchronous bit. Used on the
//   receiver's serial line and reusable for the transmitter's busy input.
//   clk   : destination clock
//   reset : synchronous, active-high; clears both flops
//   d     : asynchronous input
//   q     : synchronised output (second flop)
module dclk_rx_bit_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/dclk_rx.sv
// dclk_rx
//   Serial-to-parallel link receiver. Detects a start bit on serial_in,
//   shifts in one flit LSB first and offers it with a valid/ack handshake.
//   channel_busy back-pressures the transmitter while a frame is in flight
//   or a flit is held.
//
//   Build option: DCLK_RX_SYNC_EN -- when defined, serial_in goes through a
//   2-flop synchroniser (all sampling moves 2 cycles later). When undefined,
//   serial_in is sampled directly (transmitter must share clk).
//
//   Handshake: parallel_out is stable while valid is high; the flit is
//   consumed on a clock edge where valid and ack are both high. ack without
//   valid has no effect.
//
//   Ports
//   clk          : receiver clock
//   reset        : synchronous, active-high
//   serial_in    : link line, idle low; start bit, then FLIT_W bits LSB first
//   channel_busy : registered; high while receiving or holding a flit
//   parallel_out : received flit
//   valid        : flit available
//   ack          : consumer takes the flit
//   frame_err    : one-cycle pulse if the line is high right after the last bit
//   rx_state     : current receiver state, for observation
module dclk_rx
   import dclk_rx_pkg::*;
#(
   parameter string port = "unknown"
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              serial_in,
   output logic              channel_busy,
   output logic [FLIT_W-1:0] parallel_out,
   output logic              valid,
   input  logic              ack,
   output logic              frame_err,
   output rx_state_e         rx_state
);

   localparam int W = FLIT_W;

   logic             s;
   rx_state_e        state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     shreg;
   logic [W-1:0]     shift_next;
   logic             first_hold;
   logic             start_hit;
   logic             last_bit;
   logic             take;

`ifdef DCLK_RX_SYNC_EN
   dclk_rx_bit_sync u_line_sync (
      .clk   (clk),
      .reset (reset),
      .d     (serial_in),
      .q     (s)
   );
`else
   assign s = serial_in;
`endif

   assign shift_next = {s, shreg[W-1:1]};
   assign rx_state   = state;

   always_ff @(posedge clk) begin
      if (reset) state <= RX_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      start_hit  = 1'b0;
      last_bit   = 1'b0;
      take       = 1'b0;
      case (state)
         RX_IDLE: begin
            if (s) begin
               state_next = RX_RECV;
               start_hit  = 1'b1;
            end
         end
         RX_RECV: begin
            if (cnt == CNT_W'(W - 1)) begin
               state_next = RX_HOLD;
               last_bit   = 1'b1;
            end
         end
         RX_HOLD: begin
            // The line is not watched for a start here; the held flit must
            // be consumed before another frame may begin.
            if (ack && valid) begin
               state_next = RX_IDLE;
               take       = 1'b1;
            end
         end
         default: state_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt          <= '0;
         shreg        <= '0;
         parallel_out <= '0;
         valid        <= 1'b0;
         channel_busy <= 1'b0;
         frame_err    <= 1'b0;
         first_hold   <= 1'b0;
      end else begin
         // A well-formed frame leaves the line low after the last data bit;
         // only the first HOLD cycle is checked.
         frame_err <= (state == RX_HOLD) && first_hold && s;

         if (start_hit) begin
            cnt          <= '0;
            channel_busy <= 1'b1;
         end

         if (state == RX_RECV) begin
            shreg <= shift_next;
            if (last_bit) begin
               parallel_out <= shift_next;
               valid        <= 1'b1;
               first_hold   <= 1'b1;
            end else begin
               // Counter stops at W-1; it is cleared by the next start.
               cnt <= cnt + CNT_W'(1);
            end
         end

         if (state == RX_HOLD) begin
            first_hold <= 1'b0;
         end

         if (take) begin
            valid        <= 1'b0;
            channel_busy <= 1'b0;
         end
      end
   end

endmodule

// File: doc/dclk_rx.md
# dclk_rx

Serial-to-parallel receiver for the inter-router serial links. It sits directly downstream of the link transmitter on the same channel. It detects a frame on `serial_in`, deserialises one flit and presents it to the router input port with a valid/ack handshake. While it holds an unconsumed flit or is mid-frame, it asserts `channel_busy` back to the transmitter, which gives per-flit backpressure.

## Interface
- `port`, default "unknown": debug label used only in simulation messages.
- `W` (localparam), `HDR_SZ + PL_SZ + ADDR_SZ`: flit width, taken from the shared size defines.
- `clk`  in  1  receiver clock.
- `reset`  in  1  synchronous, active-high.
- `serial_in`  in  1  link line. Idle low. Frame is a 1-bit high start bit, then W data bits LSB first, then the line returns low.
- `channel_busy`  out  1  registered; high while receiving or holding a flit.
- `parallel_out`  out  W  received flit; stable while `valid`.
- `valid`  out  1  flit available.
- `ack`  in  1  consumer takes the flit; only meaningful while `valid`.
- `frame_err`  out  1  one-cycle pulse when the line is high in the first cycle after the last data bit.

## Operation
- States:
  - IDLE: `channel_busy`=0, `valid`=0.
  - RECV: shifting data bits in.
  - HOLD: `valid`=1, waiting for `ack`.
- IDLE -> RECV when the sampled line `s`=1 (start bit). The bit counter clears to 0 and `channel_busy` is set.
- RECV: each cycle `shreg <= {s, shreg[W-1:1]}` and the counter increments. When the counter reaches W-1, the last bit is shifted in. Next state is HOLD, with `parallel_out` loaded from the completed shift value and `valid`=1.
- HOLD: the line is not sampled for start detection. `frame_err` is checked in the first HOLD cycle only: it pulses if `s`=1.
- HOLD -> IDLE on `ack` (with `valid`=1). `valid` and `channel_busy` drop on the next edge.
- `ack` while not `valid` is ignored.
- The counter is `$clog2(W)` bits wide and never wraps: it clears on each start.
- Reset values: `channel_busy`=0, `valid`=0, `frame_err`=0, `parallel_out`=0, `shreg`=0, state IDLE.
- Reset mid-frame or mid-HOLD aborts to IDLE and drops the flit. The transmitter is reset in the same cycle by system convention.

## Timing
- Let E0 be the edge at which start is sampled (`s`=1 in IDLE).
- `channel_busy`=1 from E0. The transmitter sees it after its own 2-flop synchroniser, well before it finishes a frame, for W >= 3.
- Data bit i is sampled at edge E0+1+i.
- `valid`=1 and `parallel_out` are valid after edge E0+W. `frame_err` is evaluated at edge E0+W+1.
- `ack` sampled at edge Ea -> `valid`=0 and `channel_busy`=0 after Ea. A new start is accepted from Ea+1.
- The same-cycle ack in the first HOLD cycle is legal. Throughput limit: 1 flit per W+2 cycles plus the transmitter synchroniser latency.

## Configuration
- `DCLK_RX_SYNC_EN`
  - Defined: `serial_in` passes through a 2-flop synchroniser, and `s` is the second flop. Every sampling edge above shifts by +2 relative to the line.
  - Undefined: `s` = `serial_in` sampled directly. Use only when transmitter and receiver share `clk`.

## Structure
- Shared package/defines: `HDR_SZ`, `PL_SZ`, `ADDR_SZ`, the derived flit width, and the rx state encoding (IDLE/RECV/HOLD).
- One natural sub-module: `bit_sync`, a 2-flop synchroniser instantiated only under `DCLK_RX_SYNC_EN`. It is reusable for the transmitter's busy input.

## Test plan
Bench uses HDR_SZ=2, PL_SZ=8, ADDR_SZ=4 (W=14), macro undefined unless stated.
- Drive start bit then 0x2A5B LSB first, `ack` low -> `valid`=1 at E0+14 with `parallel_out`=0x2A5B; `channel_busy`=1 from E0 until after ack; `frame_err`=0.
- Hold `ack` low 20 cycles with further line pulses -> no state change, `parallel_out` stays 0x2A5B; `ack`=1 for 1 cycle -> `valid`=0 and `channel_busy`=0 next edge.
- Back-to-back: driven by a transmitter model obeying `channel_busy`, with `ack` tied high, send 0x0001, 0x3FFF, 0x0000 -> three `valid` pulses with those values in order, no loss.
- Line held high one extra cycle after the 14 data bits -> `frame_err` pulses once at E0+15, data still delivered.
- Assert `reset` at E0+6 -> all outputs 0 next edge, state IDLE; a fresh frame 0x1234 afterwards is received correctly.
- With `DCLK_RX_SYNC_EN` defined, repeat the first scenario -> `valid` appears 2 cycles later, same data.
